// File: rtl/pcie_sw_pkg.sv
// Shared PCIe switch types: arbiter FSM states and destination field layout.
// Configuration macro used by the arbiter: ARB_STRICT_PRIO_EN.
package pcie_sw_pkg;

    localparam int NUM_CH    = 4;
    localparam int DEST_W    = 2;
    localparam int WORD_W    = 10;
    localparam int DEST_MSB  = WORD_W - 1;
    localparam int DEST_LSB  = WORD_W - DEST_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LATCH = 2'd2,
        ST_PUSH  = 2'd3
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/vc_arbiter_4x10_rr_pick4.sv
// Combinational 4-request picker: round robin from ptr, or fixed priority
// (channel 0 highest) when ARB_STRICT_PRIO_EN is defined.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    assign any = |req;

`ifdef ARB_STRICT_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    // Lowest-numbered requester wins
    always_comb begin
        gnt_idx = 2'd0;
        priority case (1'b1)
            req[0]:  gnt_idx = 2'd0;
            req[1]:  gnt_idx = 2'd1;
            req[2]:  gnt_idx = 2'd2;
            req[3]:  gnt_idx = 2'd3;
            default: gnt_idx = 2'd0;
        endcase
    end
`else
    // Scan from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        logic [1:0] w_idx;
        gnt_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = ptr + 2'(k);
            if (req[w_idx]) gnt_idx = w_idx;
        end
    end
`endif

endmodule

// File: rtl/vc_arbiter_4x10.sv
// Ingress-to-egress VC arbiter/router: pop, latch, route by top 2 bits, push.
// Configuration macro: ARB_STRICT_PRIO_EN selects fixed priority over round robin.
module vc_arbiter_4x10 #(
    parameter int DATA_SIZE = 10,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           in_empty,
    input  logic [NUM_CH*DATA_SIZE-1:0] in_data,
    input  logic [NUM_CH-1:0]           out_pause,
    output logic [NUM_CH-1:0]           pop,
    output logic [NUM_CH-1:0]           push,
    output logic [DATA_SIZE-1:0]        data_out,
    output logic [1:0]                  grant,
    output logic                        idle
);

    import pcie_sw_pkg::*;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [1:0]             r_grant;
    logic [1:0]             r_rr_ptr;
    logic [DEST_W-1:0]      r_dest;
    logic [DATA_SIZE-1:0]   r_data;
    logic [NUM_CH-1:0]      w_req;
    logic [1:0]             w_pick;
    logic                   w_any;
    logic [DATA_SIZE-1:0]   w_slice;
    logic [NUM_CH-1:0]      w_pop;
    logic [NUM_CH-1:0]      w_push;

    assign w_req   = ~in_empty;
    assign w_slice = in_data[r_grant*DATA_SIZE +: DATA_SIZE];

    rr_pick4 u_pick (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick),
        .any     (w_any)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and strobes, decoded from registered state only
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_push      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_nxt = ST_POP;
            end
            ST_POP: begin
                w_pop       = onehot4(r_grant);
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                if (!out_pause[r_dest]) begin
                    w_push      = onehot4(r_dest);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, captured word, destination and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_dest   <= '0;
            r_data   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) r_grant <= w_pick;
            if (r_state == ST_LATCH) begin
                r_data   <= w_slice;
                r_dest   <= w_slice[DATA_SIZE-1 -: DEST_W];
`ifndef ARB_STRICT_PRIO_EN
                r_rr_ptr <= r_grant + 2'd1;
`endif
            end
        end
    end

    assign pop      = w_pop;
    assign push     = w_push;
    assign data_out = r_data;
    assign grant    = r_grant;
    assign idle     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_vc_arbiter_4x10.sv
// Bench for vc_arbiter_4x10: transaction-level model plus literal checks.
// Honours ARB_STRICT_PRIO_EN for the expected grant orders.
module tb_vc_arbiter_4x10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_empty;
    logic [39:0] in_data;
    logic [3:0]  out_pause;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [9:0]  data_out;
    logic [1:0]  grant;
    logic        idle;

    vc_arbiter_4x10 dut (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .out_pause (out_pause),
        .pop       (pop),
        .push      (push),
        .data_out  (data_out),
        .grant     (grant),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] mq[4][$];
    logic [9:0] eq[4][$];
    int         gq[$];
    logic [3:0] pause_sched;

    int         m_phase;
    int         m_grant;
    int         m_ptr;
    int         m_dest;
    logic [9:0] m_data;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_grant = 0;
        m_ptr   = 0;
        m_dest  = 0;
        m_data  = '0;
    endtask

    function automatic int pick();
        int start;
        start = m_ptr;
`ifdef ARB_STRICT_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (mq[c].size() != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int c;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                c = pick();
                if (c >= 0) begin
                    m_grant = c;
                    m_phase = 1;
                end
            end
            1: m_phase = 2;
            2: begin
                m_data  = mq[m_grant].pop_front();
                m_dest  = int'(m_data[9:8]);
                m_ptr   = (m_grant + 1) % 4;
                m_phase = 3;
            end
            default: if (!out_pause[m_dest]) m_phase = 0;
        endcase
    endtask

    task automatic compare();
        logic [3:0] ep;
        logic [3:0] eu;
        ep = (m_phase == 1) ? 4'(1 << m_grant) : 4'd0;
        eu = (m_phase == 3 && !out_pause[m_dest]) ? 4'(1 << m_dest) : 4'd0;
        chk("pop", 32'(pop), 32'(ep));
        chk("push", 32'(push), 32'(eu));
        chk("idle", 32'(idle), 32'(m_phase == 0));
        chk("grant", 32'(grant), 32'(m_grant));
        chk("data_out", 32'(data_out), 32'(m_data));
    endtask

    task automatic load(input int ch, input logic [9:0] w);
        mq[ch].push_back(w);
        eq[ch].push_back(w);
        in_empty[ch] = 1'b0;
    endtask

    task automatic cyc();
        logic [3:0] ps;
        ps = pop;
        model_step();
        @(posedge clk);
        #1;
        out_pause = pause_sched;
        for (int i = 0; i < 4; i++) begin
            if (ps[i] && eq[i].size() != 0) begin
                in_data[i*10 +: 10] = eq[i].pop_front();
                in_empty[i] = (eq[i].size() == 0);
            end
        end
        @(negedge clk);
        compare();
        if (pop != 4'd0) gq.push_back(int'(grant));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        cyc();
        reset = 1'b1;
    endtask

    task automatic run_idle(input string nm);
        int n;
        n = 0;
        while (!(m_phase == 0 && mq[0].size() == 0 && mq[1].size() == 0 &&
                 mq[2].size() == 0 && mq[3].size() == 0)) begin
            cyc();
            n++;
            if (n > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: timeout got busy expected idle", nm);
                break;
            end
        end
    endtask

    int exp_rr[8];
    int exp_a[2];
    int exp_b[2];

    initial begin
`ifdef ARB_STRICT_PRIO_EN
        exp_rr = '{0, 0, 1, 1, 2, 2, 3, 3};
        exp_b  = '{0, 2};
`else
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_b  = '{2, 0};
`endif
        exp_a       = '{0, 2};
        reset       = 1'b0;
        in_empty    = 4'b1111;
        in_data     = '0;
        out_pause   = 4'b0000;
        pause_sched = 4'b0000;
        model_reset();

        // Reset held with ch0 non-empty, then single word to dest 2
        @(negedge clk);
        load(0, 10'b10_0000_1111);
        cyc();
        cyc();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        reset = 1'b1;
        cyc();
        chk("single_pop_c1", 32'(pop), 32'b0001);
        cyc();
        chk("single_latch_push", 32'(push), 32'd0);
        cyc();
        chk("single_push_c3", 32'(push), 32'b0100);
        chk("single_data_c3", 32'(data_out), 32'h20F);
        cyc();
        chk("single_idle_c4", 32'(idle), 32'd1);

        // Round robin over four full ingress channels
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++)
                load(i, {2'((i + j) % 4), 8'(i * 16 + j)});
        gq.delete();
        run_idle("rr");
        chk("rr_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(exp_rr[i]));

        // Backpressure on dest 3; pause on dest 1 must not matter
        do_reset();
        load(2, 10'h355);
        cyc();
        pause_sched = 4'b1000;
        cyc();
        cyc();
        chk("bp_enter_push", 32'(push), 32'd0);
        pause_sched = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_hold_push", 32'(push), 32'd0);
            chk("bp_hold_data", 32'(data_out), 32'h355);
            chk("bp_hold_busy", 32'(idle), 32'd0);
        end
        pause_sched = 4'b0010;
        cyc();
        chk("bp_release_push", 32'(push), 32'b1000);
        cyc();
        chk("bp_back_idle", 32'(idle), 32'd1);
        pause_sched = 4'b0000;
        cyc();

        // Reset during a paused PUSH drops the word
        do_reset();
        load(1, 10'h2AA);
        pause_sched = 4'b0100;
        cyc();
        cyc();
        cyc();
        chk("mid_in_push", 32'(push), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_async_idle", 32'(idle), 32'd1);
        chk("mid_async_push", 32'(push), 32'd0);
        chk("mid_async_data", 32'(data_out), 32'd0);
        chk("mid_async_grant", 32'(grant), 32'd0);
        pause_sched = 4'b0000;
        cyc();
        reset = 1'b1;
        load(0, 10'h0C3);
        load(2, 10'h1F0);
        gq.delete();
        run_idle("after_rst");
        chk("after_rst_cnt", 32'(gq.size()), 32'd2);
        for (int i = 0; i < 2; i++)
            if (i < gq.size()) chk("after_rst_order", 32'(gq[i]), 32'(exp_a[i]));

        // Empty skipping with pointer at 1
        do_reset();
        load(0, 10'h011);
        run_idle("skip_prep");
        load(0, 10'h322);
        load(2, 10'h133);
        chk("skip_empty", 32'(in_empty), 32'b1010);
        gq.delete();
        run_idle("skip");
        chk("skip_cnt", 32'(gq.size()), 32'd2);
        for (int i = 0; i < 2; i++)
            if (i < gq.size()) chk("skip_order", 32'(gq[i]), 32'(exp_b[i]));
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_arbiter_4x10.md
# vc_arbiter_4x10

Round-robin arbiter and router between the four ingress `fifo_8x10` virtual-channel FIFOs and the four egress `fifo_8x10` FIFOs of the PCIe switch. It pops one 10-bit word at a time from a non-empty ingress FIFO and decodes its destination from the two MSBs. It then pushes the word into the matching egress FIFO, stalling while that egress FIFO asserts `fifo_pause`.

## Interface
Parameters:
- `DATA_SIZE`, 10: word width; bits `[DATA_SIZE-1:DATA_SIZE-2]` carry the destination channel.
- `NUM_CH`, 4: number of ingress and egress channels; fixed at 4 (2-bit grant and destination).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_empty`  in  4  `fifo_empty` of ingress FIFOs, bit i = channel i.
- `in_data`  in  4*DATA_SIZE  `data_out_pop` of ingress FIFOs; channel i in `[i*DATA_SIZE +: DATA_SIZE]`.
- `out_pause`  in  4  `fifo_pause` of egress FIFOs.
- `pop`  out  4  one-hot `read` strobe to ingress FIFOs.
- `push`  out  4  one-hot `write` strobe to egress FIFOs.
- `data_out`  out  DATA_SIZE  word driven to all egress `data_in_push`.
- `grant`  out  2  channel currently granted.
- `idle`  out  1  high when the FSM is in IDLE.

## Operation
- FSM states: IDLE, POP, LATCH, PUSH; registered, 2-bit encoding.
- IDLE:
  - Eligible set = channels with `in_empty[i]==0`.
  - If the set is non-empty, the round-robin pick starting at `rr_ptr` is registered into `grant` and the FSM moves to POP.
  - Otherwise the FSM stays in IDLE.
- POP: `pop[grant]=1` for exactly this one cycle; next state LATCH.
- LATCH:
  - `in_data` slice `grant` is captured into `data_out`.
  - `dest` is captured from the slice's top 2 bits.
  - `rr_ptr` is updated to `grant+1` (mod 4).
  - Next state PUSH.
- PUSH:
  - If `out_pause[dest]==0`: `push[dest]=1` for this cycle, then IDLE.
  - Otherwise: hold in PUSH with `push=0`, `data_out` stable.
- Only `out_pause[dest]` gates the push; pause on other egress channels is ignored.
- `pop` and `push` are decoded from registered state and registers, never from `in_*` directly. They are never both non-zero in the same cycle.
- Each `pop` and `push` is one-hot or zero.
- `in_empty` is sampled only in IDLE. A channel going empty after the grant is not re-checked, because the pop decision was already made on a non-empty flag.

## Timing
- Reset asserted (async, any state): state IDLE, `pop=0`, `push=0`, `data_out=0`, `grant=0`, `rr_ptr=0`, `dest=0`, `idle=1`.
- Reset mid-PUSH: the word is dropped; no push is issued.
- Latency, non-empty flag seen in IDLE at edge 0:
  - `pop` high in cycle 1 (POP).
  - Data captured at the end of cycle 2 (LATCH), matching the one-cycle registered `data_out_pop` of `fifo_8x10`.
  - `push` high in cycle 3 if not paused.
- Minimum 4 cycles per word.
- Pause arriving in the LATCH cycle stalls PUSH. Pause released at edge k gives `push` in cycle k+1.
- `rr_ptr` wraps 3 → 0.

## Configuration
- `ARB_STRICT_PRIO_EN`:
  - Defined: fixed priority, channel 0 highest, 3 lowest; `rr_ptr` unused and held at 0.
  - Undefined (default): round robin as described above.

## Structure
- Shared package `pcie_sw_pkg` holds:
  - FSM state encodings (`ST_IDLE`, `ST_POP`, `ST_LATCH`, `ST_PUSH`).
  - `NUM_CH`, `DEST_W=2`, and the destination field position constants, shared with the egress FIFO wrappers.
- One sub-module, `rr_pick4`: combinational 4-request picker taking `req[3:0]` and `ptr[1:0]`, returning `gnt_idx[1:0]` and `any`. It contains the strict-priority variant under `ARB_STRICT_PRIO_EN`.

## Test plan
- Reset check: hold `reset=0` with ingress non-empty → all outputs zero, `idle=1`. Release → `pop=0001` in cycle 1.
- Single word: `in_empty=1110`, channel-0 word `10'b10_00001111` → `pop[0]` cycle 1, `push=0100`, `data_out=0x20F` cycle 3, back to IDLE cycle 4.
- Round robin: all four ingress FIFOs hold 2 words → grant order 0,1,2,3,0,1,2,3. With `ARB_STRICT_PRIO_EN`, the order is 0,0,1,1,2,2,3,3.
- Backpressure: `out_pause[3]=1` for 5 cycles while routing a word to dest 3 → FSM stays in PUSH, `push=0`, `data_out` stable. `push=1000` one cycle after pause drops. `out_pause[1]=1` does not stall a dest-3 word.
- Reset mid-operation: assert `reset` during PUSH → `push` never pulses and state returns to IDLE asynchronously. After release, the next grant starts at channel 0.
- Empty skipping: `in_empty=1010`, `rr_ptr=1` → grant 2, then 0, never 1 or 3.
